// File: rtl/result_drain_queue.sv
// rtl/result_drain_queue.sv - per-column FIFOs that reassemble skewed mesh outputs into handshaked rows
// Optional row checksum output enabled by RESULT_DRAIN_ROW_CHECKSUM_EN.
module result_drain_queue #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [DATA_WIDTH-1:0]   south_i [0:N-1],
  input  logic [N-1:0]            south_valid_i,
  output logic [DATA_WIDTH-1:0]   row_data_o [0:N-1],
  output logic                    row_valid_o,
  input  logic                    row_ready_i,
  output logic [$clog2(N)-1:0]    row_idx_o,
  output logic                    row_last_o,
  output logic                    done_o,
`ifdef RESULT_DRAIN_ROW_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0]   row_checksum_o,
`endif
  output logic                    overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(N);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         row_idx_q, row_idx_d;
  logic                  overflow_q, overflow_d;
  logic [PW-1:0]         wr_ptr_q [N];
  logic [PW-1:0]         wr_ptr_d [N];
  logic [PW-1:0]         rd_ptr_q [N];
  logic [PW-1:0]         rd_ptr_d [N];
  logic [DATA_WIDTH-1:0] mem_q [N][DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [N][DEPTH];

  logic [N-1:0]          empty;
  logic [N-1:0]          full;
  logic                  collecting;
  logic                  pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      empty[j] = (wr_ptr_q[j] == rd_ptr_q[j]);
      full[j]  = (wr_ptr_q[j][AW] != rd_ptr_q[j][AW]) &&
                 (wr_ptr_q[j][AW-1:0] == rd_ptr_q[j][AW-1:0]);
    end
  end

  assign collecting  = (state_q == ST_COLLECT);
  assign row_valid_o = collecting && (empty == '0);
  assign pop         = row_valid_o && row_ready_i;

  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    if (start_i) begin
      state_d    = ST_COLLECT;
      row_idx_d  = '0;
      overflow_d = 1'b0;
      for (int j = 0; j < N; j++) begin
        wr_ptr_d[j] = '0;
        rd_ptr_d[j] = '0;
      end
    end else if (collecting) begin
      for (int j = 0; j < N; j++) begin
        if (pop) begin
          rd_ptr_d[j] = rd_ptr_q[j] + PW'(1);
        end
        // A same-cycle pop frees the head slot, so a full column can still accept.
        if (south_valid_i[j]) begin
          if (!full[j] || pop) begin
            mem_d[j][wr_ptr_q[j][AW-1:0]] = south_i[j];
            wr_ptr_d[j] = wr_ptr_q[j] + PW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      if (pop) begin
        row_idx_d = row_idx_q + IW'(1);
        if (row_idx_q == IW'(N - 1)) begin
          state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      row_idx_q  <= '0;
      overflow_q <= 1'b0;
      for (int j = 0; j < N; j++) begin
        wr_ptr_q[j] <= '0;
        rd_ptr_q[j] <= '0;
      end
    end else begin
      state_q    <= state_d;
      row_idx_q  <= row_idx_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Heads are gated so stale storage never leaks out when no row is presented.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      row_data_o[j] = row_valid_o ? mem_q[j][rd_ptr_q[j][AW-1:0]] : '0;
    end
  end

  assign row_idx_o  = row_idx_q;
  assign row_last_o = row_valid_o && (row_idx_q == IW'(N - 1));
  assign done_o     = (state_q == ST_DONE);
  assign overflow_o = overflow_q;

`ifdef RESULT_DRAIN_ROW_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;

  always_comb begin
    checksum = '0;
    for (int j = 0; j < N; j++) begin
      checksum = checksum ^ row_data_o[j];
    end
  end

  assign row_checksum_o = checksum;
`endif

endmodule

// File: tb/tb_result_drain_queue.sv
// tb/tb_result_drain_queue.sv - directed vector bench for result_drain_queue (N=4, DEPTH=4)
module tb_result_drain_queue;
  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef logic [0:3][31:0] row_t;

  typedef struct {
    logic       start;
    logic [3:0] sv;
    row_t       din;
    logic       ready;
    logic       ev;
    logic [1:0] ei;
    logic       el;
    logic       ed;
    logic       eo;
    row_t       edat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ready;
  logic [DW-1:0] south [0:N-1];
  logic [N-1:0]  sv;
  logic [DW-1:0] row_data [0:N-1];
  logic          row_valid;
  logic [1:0]    row_idx;
  logic          row_last;
  logic          done;
  logic          ovf;
`ifdef RESULT_DRAIN_ROW_CHECKSUM_EN
  logic [DW-1:0] csum;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs [12];

  always #5 clk = ~clk;

  result_drain_queue #(.N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .south_i       (south),
    .south_valid_i (sv),
    .row_data_o    (row_data),
    .row_valid_o   (row_valid),
    .row_ready_i   (ready),
    .row_idx_o     (row_idx),
    .row_last_o    (row_last),
    .done_o        (done),
`ifdef RESULT_DRAIN_ROW_CHECKSUM_EN
    .row_checksum_o(csum),
`endif
    .overflow_o    (ovf)
  );

  function automatic vec_t mk(input logic s, input logic [3:0] v, input row_t din, input logic r,
                              input logic ev, input logic [1:0] ei, input logic el,
                              input logic ed, input logic eo, input row_t edat);
    vec_t t;
    t.start = s; t.sv = v; t.din = din; t.ready = r;
    t.ev = ev; t.ei = ei; t.el = el; t.ed = ed; t.eo = eo; t.edat = edat;
    return t;
  endfunction

  function automatic row_t seq_row(input logic [31:0] base);
    row_t r;
    for (int j = 0; j < 4; j++) r[j] = base + 32'(j);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [3:0] v, input row_t d, input logic r);
    start = s;
    sv    = v;
    for (int j = 0; j < N; j++) south[j] = d[j];
    ready = r;
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic ev, input logic [1:0] ei, input logic el,
                     input logic ed, input logic eo, input row_t edat);
    logic [31:0] x;
    #1;
    cmp({nm, " valid"}, 32'(row_valid), 32'(ev));
    cmp({nm, " idx"},   32'(row_idx),   32'(ei));
    cmp({nm, " last"},  32'(row_last),  32'(el));
    cmp({nm, " done"},  32'(done),      32'(ed));
    cmp({nm, " ovf"},   32'(ovf),       32'(eo));
    x = '0;
    for (int j = 0; j < N; j++) begin
      cmp($sformatf("%s data%0d", nm, j), row_data[j], edat[j]);
      x = x ^ edat[j];
    end
`ifdef RESULT_DRAIN_ROW_CHECKSUM_EN
    cmp({nm, " csum"}, csum, x);
`endif
  endtask

  initial begin
    row_t d;
    row_t z;
    z = '0;

    // Skewed fill: column j lags by j cycles, rows drain one per cycle once column 3 arrives.
    vecs[0]  = mk(1, 4'b0000, z, 1, 0, 0, 0, 0, 0, z);
    vecs[1]  = mk(0, 4'b0001, {32'h00, 32'h00, 32'h00, 32'h00}, 1, 0, 0, 0, 0, 0, z);
    vecs[2]  = mk(0, 4'b0011, {32'h10, 32'h01, 32'h00, 32'h00}, 1, 0, 0, 0, 0, 0, z);
    vecs[3]  = mk(0, 4'b0111, {32'h20, 32'h11, 32'h02, 32'h00}, 1, 0, 0, 0, 0, 0, z);
    vecs[4]  = mk(0, 4'b1111, {32'h30, 32'h21, 32'h12, 32'h03}, 1, 0, 0, 0, 0, 0, z);
    vecs[5]  = mk(0, 4'b1110, {32'h00, 32'h31, 32'h22, 32'h13}, 1, 1, 0, 0, 0, 0,
                  {32'h00, 32'h01, 32'h02, 32'h03});
    vecs[6]  = mk(0, 4'b1100, {32'h00, 32'h00, 32'h32, 32'h23}, 1, 1, 1, 0, 0, 0,
                  {32'h10, 32'h11, 32'h12, 32'h13});
    vecs[7]  = mk(0, 4'b1000, {32'h00, 32'h00, 32'h00, 32'h33}, 1, 1, 2, 0, 0, 0,
                  {32'h20, 32'h21, 32'h22, 32'h23});
    vecs[8]  = mk(0, 4'b0000, z, 1, 1, 3, 1, 0, 0, {32'h30, 32'h31, 32'h32, 32'h33});
    vecs[9]  = mk(0, 4'b0000, z, 1, 0, 0, 0, 1, 0, z);
    vecs[10] = mk(0, 4'b1111, {32'h55, 32'h55, 32'h55, 32'h55}, 1, 0, 0, 0, 1, 0, z);
    vecs[11] = mk(0, 4'b0000, z, 1, 0, 0, 0, 1, 0, z);

    rst = 1'b1;
    drive(0, 4'b0000, z, 0);
    tick();
    tick();
    chk("reset", 0, 0, 0, 0, 0, z);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      tick();
      drive(vecs[i].start, vecs[i].sv, vecs[i].din, vecs[i].ready);
      chk($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].el, vecs[i].ed, vecs[i].eo,
          vecs[i].edat);
    end

    // Backpressure: row 0 held for six stalled cycles.
    tick(); drive(1, 4'b0000, z, 0);
    tick(); drive(0, 4'b1111, seq_row(32'hA000_0000), 0);
    chk("bp_first", 0, 0, 0, 0, 0, z);
    tick(); drive(0, 4'b1111, seq_row(32'hB000_0000), 0);
    chk("bp_stall", 1, 0, 0, 0, 0, seq_row(32'hA000_0000));
    for (int k = 0; k < 5; k++) begin
      tick(); drive(0, 4'b0000, z, 0);
      chk("bp_stall", 1, 0, 0, 0, 0, seq_row(32'hA000_0000));
    end
    tick(); drive(0, 4'b0000, z, 1);
    chk("bp_hs0", 1, 0, 0, 0, 0, seq_row(32'hA000_0000));
    tick(); drive(0, 4'b0000, z, 1);
    chk("bp_hs1", 1, 1, 0, 0, 0, seq_row(32'hB000_0000));
    tick(); drive(0, 4'b0000, z, 0);
    chk("bp_empty", 0, 2, 0, 0, 0, z);

    // Overflow: five words into column 0 with no pops.
    tick(); drive(1, 4'b0000, z, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      d = z; d[0] = 32'hC0 + 32'(k);
      drive(0, 4'b0001, d, 0);
      chk("ovf_fill", 0, 0, 0, 0, 0, z);
    end
    for (int r = 0; r < 4; r++) begin
      tick();
      d = seq_row(32'(16 * r)); d[0] = 32'h0;
      drive(0, 4'b1110, d, 0);
      d = seq_row(32'h0); d[0] = 32'hC0;
      if (r == 0) chk("ovf_set", 0, 0, 0, 0, 1, z);
      else        chk("ovf_hold", 1, 0, 0, 0, 1, d);
    end
    for (int r = 0; r < 4; r++) begin
      tick(); drive(0, 4'b0000, z, 1);
      d = seq_row(32'(16 * r)); d[0] = 32'hC0 + 32'(r);
      chk("ovf_drain", 1, 2'(r), (r == 3), 0, 1, d);
    end
    tick(); drive(0, 4'b0000, z, 0);
    chk("ovf_done", 0, 0, 0, 1, 1, z);
    tick(); drive(1, 4'b0000, z, 0);
    tick(); drive(0, 4'b0000, z, 0);
    chk("ovf_clear", 0, 0, 0, 0, 0, z);

    // Full column 0 accepts a push in the same cycle as a handshake.
    for (int r = 0; r < 4; r++) begin
      tick();
      if (r == 0) drive(0, 4'b1111, seq_row(32'h100), 0);
      else begin
        d = z; d[0] = 32'h100 + 32'(16 * r);
        drive(0, 4'b0001, d, 0);
      end
      if (r == 0) chk("fpp_fill", 0, 0, 0, 0, 0, z);
      else        chk("fpp_fill", 1, 0, 0, 0, 0, seq_row(32'h100));
    end
    tick();
    d = z; d[0] = 32'hAA;
    drive(0, 4'b0001, d, 1);
    chk("fpp_hs", 1, 0, 0, 0, 0, seq_row(32'h100));
    tick(); drive(0, 4'b0000, z, 0);
    chk("fpp_noovf", 0, 1, 0, 0, 0, z);
    for (int r = 1; r < 4; r++) begin
      tick(); drive(0, 4'b1110, seq_row(32'h100 + 32'(16 * r)), 1);
      if (r == 1) chk("fpp_row", 0, 1, 0, 0, 0, z);
      else        chk("fpp_row", 1, 2'(r - 1), 0, 0, 0, seq_row(32'h100 + 32'(16 * (r - 1))));
    end
    tick(); drive(0, 4'b0000, z, 1);
    chk("fpp_last", 1, 3, 1, 0, 0, seq_row(32'h130));
    tick(); drive(0, 4'b0000, z, 0);
    chk("fpp_done", 0, 0, 0, 1, 0, z);

    // Restart after two rows; the handshake in the start cycle must be ignored.
    tick(); drive(1, 4'b0000, z, 0);
    for (int r = 0; r < 4; r++) begin
      tick(); drive(0, 4'b1111, seq_row(32'h200 + 32'(16 * r)), 0);
      if (r == 0) chk("rs_fill", 0, 0, 0, 0, 0, z);
      else        chk("rs_fill", 1, 0, 0, 0, 0, seq_row(32'h200));
    end
    tick(); drive(0, 4'b0000, z, 1);
    chk("rs_row0", 1, 0, 0, 0, 0, seq_row(32'h200));
    tick(); drive(0, 4'b0000, z, 1);
    chk("rs_row1", 1, 1, 0, 0, 0, seq_row(32'h210));
    tick(); drive(1, 4'b0000, z, 1);
    chk("rs_start", 1, 2, 0, 0, 0, seq_row(32'h220));
    tick(); drive(0, 4'b0000, z, 0);
    chk("rs_clear", 0, 0, 0, 0, 0, z);
    for (int r = 0; r < 4; r++) begin
      tick(); drive(0, 4'b1111, seq_row(32'h300 + 32'(16 * r)), 1);
      if (r == 0) chk("rs_new", 0, 0, 0, 0, 0, z);
      else        chk("rs_new", 1, 2'(r - 1), 0, 0, 0, seq_row(32'h300 + 32'(16 * (r - 1))));
    end
    tick(); drive(0, 4'b0000, z, 1);
    chk("rs_last", 1, 3, 1, 0, 0, seq_row(32'h330));
    tick(); drive(0, 4'b0000, z, 0);
    chk("rs_done", 0, 0, 0, 1, 0, z);

    // Reset while a row is valid and overflow is set; reset beats a same-cycle start.
    tick(); drive(1, 4'b0000, z, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      d = seq_row(32'hE0); d[0] = 32'hE0 + 32'(k);
      drive(0, (k == 0) ? 4'b1111 : 4'b0001, d, 0);
      if (k == 0) chk("rm_fill", 0, 0, 0, 0, 0, z);
      else        chk("rm_fill", 1, 0, 0, 0, 0, seq_row(32'hE0));
    end
    tick(); drive(0, 4'b0000, z, 0);
    chk("rm_pre", 1, 0, 0, 0, 1, seq_row(32'hE0));
    tick(); rst = 1'b1; drive(1, 4'b1111, seq_row(32'hF0), 1);
    tick(); rst = 1'b0; drive(0, 4'b1111, seq_row(32'hF0), 1);
    chk("rm_reset", 0, 0, 0, 0, 0, z);
    tick(); drive(0, 4'b0000, z, 0);
    chk("rm_idle", 0, 0, 0, 0, 0, z);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
